// File: rtl/parking_gate_controller_if.sv
// parking_gate_controller_if: gate requests, door commands and occupancy status
interface parking_gate_controller_if #(
  parameter int N_ENTRY = 2,
  parameter int N_EXIT  = 2,
  parameter int CNT_W   = 4
);
  logic [N_ENTRY-1:0] car_entry_request;
  logic [N_EXIT-1:0]  car_exit_request;
  logic [N_ENTRY-1:0] open_entry_door;
  logic [N_EXIT-1:0]  open_exit_door;
  logic [CNT_W-1:0]   occupancy;
  logic               garage_is_complete;
  logic               garage_is_empty;
  logic               entry_rejected;
  modport master (
    output car_entry_request, car_exit_request,
    input  open_entry_door, open_exit_door, occupancy,
    input  garage_is_complete, garage_is_empty, entry_rejected
  );
  modport slave (
    input  car_entry_request, car_exit_request,
    output open_entry_door, open_exit_door, occupancy,
    output garage_is_complete, garage_is_empty, entry_rejected
  );
endinterface

// File: rtl/parking_gate_controller.sv
// parking_gate_controller: per-gate door FSMs with capacity-limited entry and exit grants
module parking_gate_controller #(
  parameter int MAX_NUM   = 10,
  parameter int CNT_W     = 4,
  parameter int N_ENTRY   = 2,
  parameter int N_EXIT    = 2,
  parameter int DOOR_HOLD = 4
) (
  input logic clock,
  input logic reset,
  parking_gate_controller_if.slave bus
);
  localparam int N  = N_ENTRY + N_EXIT;
  localparam int HW = $clog2(DOOR_HOLD + 1);
  typedef enum logic [1:0] {IDLE, OPEN, COOLDOWN} st_t;
  st_t              st   [N];
  logic [HW-1:0]    hold [N];
  logic [N-1:0]     req, grant, door;
  logic [CNT_W-1:0] occ;
  logic [CNT_W:0]   ent_room, ent_cnt, ext_cnt;
  logic             ent_rej, rej;
  assign req      = {bus.car_exit_request, bus.car_entry_request};
  assign ent_room = CNT_W'(MAX_NUM) - {1'b0, occ};
  // Both limits use start-of-cycle occupancy, so exits never make room for same-cycle entries
  always_comb begin
    grant   = '0;
    ent_cnt = '0;
    ext_cnt = '0;
    ent_rej = 1'b0;
    for (int i = 0; i < N_ENTRY; i++)
      if (st[i] == IDLE && req[i]) begin
        if (ent_cnt < ent_room) begin
          grant[i] = 1'b1;
          ent_cnt  = ent_cnt + 1'b1;
        end else ent_rej = 1'b1;
      end
    for (int i = N_ENTRY; i < N; i++)
      if (st[i] == IDLE && req[i] && ext_cnt < {1'b0, occ}) begin
        grant[i] = 1'b1;
        ext_cnt  = ext_cnt + 1'b1;
      end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        st[i]   <= IDLE;
        hold[i] <= '0;
      end
      door <= '0;
      occ  <= '0;
      rej  <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++)
        if (grant[i]) begin
          st[i]   <= OPEN;
          hold[i] <= HW'(DOOR_HOLD - 1);
          door[i] <= 1'b1;
        end else if (st[i] == OPEN) begin
          if (hold[i] == '0) begin
            st[i]   <= COOLDOWN;
            door[i] <= 1'b0;
          end else hold[i] <= hold[i] - 1'b1;
        end else if (st[i] == COOLDOWN) st[i] <= IDLE;
      occ <= CNT_W'({1'b0, occ} + ent_cnt - ext_cnt);
      rej <= ent_rej;
    end
  end
  assign bus.open_entry_door    = door[N_ENTRY-1:0];
  assign bus.open_exit_door     = door[N-1:N_ENTRY];
  assign bus.occupancy          = occ;
  assign bus.garage_is_complete = occ == CNT_W'(MAX_NUM);
  assign bus.garage_is_empty    = occ == '0;
  assign bus.entry_rejected     = rej;
endmodule
